// File: rtl/cordic_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cordic_issue_scheduler
// Description : Round-robin issue of NUM_REQ requesters into one shared,
//               fully pipelined CORDIC core, with mode-safe draining and
//               requester-tagged result return.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_issue_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 28,
    parameter int ID_W    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_x,
    input  logic [32*NUM_REQ-1:0]   req_y,
    input  logic [32*NUM_REQ-1:0]   req_angle,
    input  logic [2*NUM_REQ-1:0]    req_mode,
    output logic [31:0]             core_x,
    output logic [31:0]             core_y,
    output logic [31:0]             core_angle,
    output logic [1:0]              core_mode,
    input  logic [31:0]             core_rx,
    input  logic [31:0]             core_ry,
    input  logic [31:0]             core_rangle,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_x,
    output logic [31:0]             rsp_y,
    output logic [31:0]             rsp_angle,
    output logic                    busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [1:0] c_MODE_CIRC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [LATENCY-1:0] r_tok_v;
    logic [ID_W-1:0]    r_tok_id [LATENCY];

    logic [31:0]        r_core_x;
    logic [31:0]        r_core_y;
    logic [31:0]        r_core_angle;
    logic [1:0]         r_core_mode;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [31:0]        r_rsp_x;
    logic [31:0]        r_rsp_y;
    logic [31:0]        r_rsp_angle;

    logic               w_found;
    logic [PW-1:0]      w_idx;
    int                 w_j;
    logic [1:0]         w_cand_mode;
    logic               w_grant;
    logic               w_accept;
    logic               w_exit;
    logic [ID_W-1:0]    w_exit_id;

    // Mode 01 is an alias of LINEAR; fold it before any comparison or load.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b01) ? 2'b00 : m;
    endfunction

    // First valid requester after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && req_valid[w_j]) begin
                w_found = 1'b1;
                w_idx   = PW'(w_j);
            end
        end
    end

    assign w_cand_mode = norm_mode(req_mode[2*w_idx +: 2]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A mode mismatch in RUN never skips ahead: the head candidate waits
    // for a full drain so no requester can be starved by others' modes.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_found) begin
                    if (w_cand_mode == r_core_mode) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_grant) begin
            req_ready[w_idx] = 1'b1;
        end
    end

    assign w_accept  = w_grant;
    assign w_exit    = r_tok_v[LATENCY-1];
    assign w_exit_id = r_tok_id[LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr        <= PW'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_tok_v      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tok_id[i] <= '0;
            end
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_core_angle <= '0;
            r_core_mode  <= c_MODE_CIRC;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_angle  <= '0;
        end else begin
            if (w_accept) begin
                r_core_x     <= req_x[32*w_idx +: 32];
                r_core_y     <= req_y[32*w_idx +: 32];
                r_core_angle <= req_angle[32*w_idx +: 32];
                r_core_mode  <= w_cand_mode;
                r_ptr        <= w_idx;
            end

            // Token pipe mirrors the core latency so results can be tagged.
            r_tok_v[0]  <= w_accept;
            r_tok_id[0] <= w_accept ? ID_W'(w_idx) : '0;
            for (int i = 1; i < LATENCY; i++) begin
                r_tok_v[i]  <= r_tok_v[i-1];
                r_tok_id[i] <= r_tok_id[i-1];
            end

            if (w_accept && !w_exit) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_accept && w_exit) begin
                r_cnt <= r_cnt - CW'(1);
            end

            r_rsp_valid <= w_exit;
            if (w_exit) begin
                r_rsp_id    <= w_exit_id;
                r_rsp_x     <= core_rx;
                r_rsp_y     <= core_ry;
                r_rsp_angle <= core_rangle;
            end
        end
    end

    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign core_angle = r_core_angle;
    assign core_mode  = r_core_mode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_x      = r_rsp_x;
    assign rsp_y      = r_rsp_y;
    assign rsp_angle  = r_rsp_angle;
    assign busy       = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_cordic_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_issue_scheduler
// Description : Directed, scoreboard-checked bench with a stand-in delay core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_issue_scheduler;

    localparam int NR  = 4;
    localparam int LAT = 28;
    localparam int IDW = 2;
    localparam logic [31:0] c_KX = 32'h5A5A_0001;
    localparam logic [31:0] c_KY = 32'h0F0F_1234;
    localparam logic [31:0] c_KA = 32'hC3C3_8000;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_x, req_y, req_angle;
    logic [2*NR-1:0]   req_mode;
    logic [31:0]       core_x, core_y, core_angle;
    logic [1:0]        core_mode;
    logic [31:0]       core_rx, core_ry, core_rangle;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_x, rsp_y, rsp_angle;
    logic              busy;

    always #5 clock = ~clock;

    cordic_issue_scheduler #(.NUM_REQ(NR), .LATENCY(LAT), .ID_W(IDW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_angle(req_angle), .req_mode(req_mode),
        .core_x(core_x), .core_y(core_y), .core_angle(core_angle), .core_mode(core_mode),
        .core_rx(core_rx), .core_ry(core_ry), .core_rangle(core_rangle),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_angle(rsp_angle), .busy(busy)
    );

    // Stand-in core: operands registered at edge k appear on core_r* in time
    // to be sampled at edge k+LAT, each lane scrambled by a distinct key.
    logic [31:0] fx [LAT-1];
    logic [31:0] fy [LAT-1];
    logic [31:0] fa [LAT-1];
    always @(posedge clock) begin
        fx[0] <= core_x;
        fy[0] <= core_y;
        fa[0] <= core_angle;
        for (int i = 1; i < LAT-1; i++) begin
            fx[i] <= fx[i-1];
            fy[i] <= fy[i-1];
            fa[i] <= fa[i-1];
        end
    end
    assign core_rx     = fx[LAT-2] ^ c_KX;
    assign core_ry     = fy[LAT-2] ^ c_KY;
    assign core_rangle = fa[LAT-2] ^ c_KA;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    x;
        logic [31:0]    y;
        logic [31:0]    a;
    } exp_t;
    exp_t sb [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int acc_count    = 0;
    int rsp_count    = 0;
    int gcnt [NR];
    int wcnt [NR];
    int wmax [NR];
    bit track = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] nmode(input logic [1:0] m);
        return (m == 2'b01) ? 2'b00 : m;
    endfunction

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] a, input logic [1:0] m);
        req_x[32*i +: 32]     = x;
        req_y[32*i +: 32]     = y;
        req_angle[32*i +: 32] = a;
        req_mode[2*i +: 2]    = m;
    endtask

    // Monitor: pushes expectations on accept, pops and compares on response.
    initial begin
        logic [1:0] mode_prev;
        logic       busy_prev;
        logic       reset_prev;
        logic       mode_pend;
        logic [1:0] mode_exp;
        exp_t       e;
        mode_prev  = 2'b10;
        busy_prev  = 1'b0;
        reset_prev = 1'b1;
        mode_pend  = 1'b0;
        mode_exp   = 2'b00;
        forever begin
            @(negedge clock);
            if (rsp_valid) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
                    chk("rsp_x", {32'd0, rsp_x}, {32'd0, e.x});
                    chk("rsp_y", {32'd0, rsp_y}, {32'd0, e.y});
                    chk("rsp_angle", {32'd0, rsp_angle}, {32'd0, e.a});
                end
            end
            if (!reset_prev && (core_mode !== mode_prev)) begin
                chk("mode_change_while_busy", {63'd0, busy_prev}, 64'd0);
            end
            if (mode_pend && !reset_prev) begin
                chk("core_mode_load", {62'd0, core_mode}, {62'd0, mode_exp});
            end
            mode_pend = 1'b0;
            if (reset) begin
                sb.delete();
            end else if (|(req_valid & req_ready)) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        e.id = IDW'(i);
                        e.x  = req_x[32*i +: 32] ^ c_KX;
                        e.y  = req_y[32*i +: 32] ^ c_KY;
                        e.a  = req_angle[32*i +: 32] ^ c_KA;
                        sb.push_back(e);
                        mode_exp  = nmode(req_mode[2*i +: 2]);
                        mode_pend = 1'b1;
                        acc_count++;
                        gcnt[i]++;
                    end
                end
            end
            if (track) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i] && !req_ready[i]) wcnt[i]++;
                    else wcnt[i] = 0;
                    if (wcnt[i] > wmax[i]) wmax[i] = wcnt[i];
                end
            end
            mode_prev  = core_mode;
            busy_prev  = busy;
            reset_prev = reset;
        end
    end

    task automatic wait_rsp(output int n);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            n++;
            if (rsp_valid) break;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (!busy) break;
        end
        chk("idle_reached", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int n;
        int a0, r0;
        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_angle = '0;
        req_mode  = '0;
        for (int i = 0; i < NR; i++) begin
            gcnt[i] = 0; wcnt[i] = 0; wmax[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_core_x", {32'd0, core_x}, 64'd0);
        chk("rst_core_angle", {32'd0, core_angle}, 64'd0);
        chk("rst_core_mode", {62'd0, core_mode}, 64'd2);
        chk("rst_rsp_x", {32'd0, rsp_x}, 64'd0);

        // Single request from requester 2
        @(posedge clock); #1;
        set_req(2, 32'h1000_0000, 32'h0, 32'h1000_0000, 2'b10);
        req_valid = 4'b0100;
        @(negedge clock);
        chk("t1_ready", {60'd0, req_ready}, 64'h4);
        @(posedge clock); #1 req_valid = '0;
        wait_rsp(n);
        chk("t1_latency", 64'(n), 64'd29);
        chk("t1_rsp_id", {62'd0, rsp_id}, 64'd2);
        chk("t1_rsp_x", {32'd0, rsp_x}, {32'd0, 32'h1000_0000 ^ c_KX});
        chk("t1_busy_after", {63'd0, busy}, 64'd0);

        // Requesters 0 and 1 alternate
        @(posedge clock); #1;
        set_req(0, 32'h0000_0A00, 32'h0000_0A01, 32'h0000_0A02, 2'b10);
        set_req(1, 32'h0000_0B00, 32'h0000_0B01, 32'h0000_0B02, 2'b10);
        req_valid = 4'b0011;
        for (int g = 0; g < 8; g++) begin
            @(negedge clock);
            chk("t2_grant", {60'd0, req_ready}, (g % 2 == 0) ? 64'h1 : 64'h2);
            @(posedge clock);
        end
        #1 req_valid = '0;
        wait_rsp(n);
        chk("t2_first_id", {62'd0, rsp_id}, 64'd0);
        for (int j = 1; j < 8; j++) begin
            @(negedge clock);
            chk("t2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("t2_rsp_id", {62'd0, rsp_id}, 64'(j % 2));
        end
        wait_idle();

        // Mode switch drains before requester 1 (mode 11) is issued
        @(posedge clock); #1;
        set_req(0, 32'h0000_0C00, 32'h0000_0C01, 32'h0000_0C02, 2'b10);
        req_valid = 4'b0001;
        repeat (4) @(posedge clock);
        #1;
        set_req(1, 32'h0000_0D00, 32'h0000_0D01, 32'h0000_0D02, 2'b11);
        req_valid = 4'b0011;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (req_ready == 4'b0010) break;
            chk("t3_no_grant", {60'd0, req_ready}, 64'd0);
            chk("t3_mode_hold", {62'd0, core_mode}, 64'd2);
        end
        chk("t3_ready1", {60'd0, req_ready}, 64'h2);
        chk("t3_busy_zero", {63'd0, busy}, 64'd0);
        @(posedge clock); #1 req_valid = '0;
        @(negedge clock);
        chk("t3_mode_new", {62'd0, core_mode}, 64'd3);
        wait_idle();

        // Mode 01 is issued as LINEAR
        @(posedge clock); #1;
        set_req(3, 32'h0000_0E00, 32'h0000_0E01, 32'h0000_0E02, 2'b01);
        req_valid = 4'b1000;
        @(negedge clock);
        chk("t4_ready", {60'd0, req_ready}, 64'h8);
        @(posedge clock); #1 req_valid = '0;
        wait_rsp(n);
        chk("t4_latency", 64'(n), 64'd29);
        chk("t4_rsp_id", {62'd0, rsp_id}, 64'd3);
        chk("t4_core_mode", {62'd0, core_mode}, 64'd0);
        wait_idle();

        // Reset with operations in flight
        @(posedge clock); #1;
        set_req(0, 32'h0000_0F00, 32'h0000_0F01, 32'h0000_0F02, 2'b10);
        req_valid = 4'b0001;
        repeat (5) @(posedge clock);
        #1 req_valid = '0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_core_mode", {62'd0, core_mode}, 64'd2);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            chk("t5_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(posedge clock); #1;
        set_req(1, 32'h0000_1100, 32'h0000_1101, 32'h0000_1102, 2'b10);
        req_valid = 4'b0010;
        @(negedge clock);
        chk("t5_ready", {60'd0, req_ready}, 64'h2);
        @(posedge clock); #1 req_valid = '0;
        wait_rsp(n);
        chk("t5_latency", 64'(n), 64'd29);
        chk("t5_rsp_id", {62'd0, rsp_id}, 64'd1);
        wait_idle();

        // All requesters, mixed modes, fairness and response accounting
        a0 = acc_count;
        r0 = rsp_count;
        for (int i = 0; i < NR; i++) begin
            gcnt[i] = 0; wcnt[i] = 0; wmax[i] = 0;
        end
        @(posedge clock); #1;
        set_req(0, 32'h0000_2000, 32'h0000_2001, 32'h0000_2002, 2'b10);
        set_req(1, 32'h0000_2100, 32'h0000_2101, 32'h0000_2102, 2'b10);
        set_req(2, 32'h0000_2200, 32'h0000_2201, 32'h0000_2202, 2'b11);
        set_req(3, 32'h0000_2300, 32'h0000_2301, 32'h0000_2302, 2'b00);
        req_valid = 4'b1111;
        track = 1'b1;
        repeat (200) @(posedge clock);
        #1 req_valid = '0;
        track = 1'b0;
        wait_idle();
        for (int i = 0; i < NR; i++) begin
            chk("t6_max_wait_ok", {63'd0, (wmax[i] <= 3 * (LAT + 2))}, 64'd1);
            chk("t6_granted", {63'd0, (gcnt[i] > 0)}, 64'd1);
        end
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);
        chk("t6_acc_eq_rsp", 64'(acc_count - a0), 64'(rsp_count - r0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
